// File: rtl/fx_requant_pipe.sv
// rtl/fx_requant_pipe.sv - two-stage signed fixed-point requantizer (round, then overflow) with valid/ready.
// Optional overflow event counter enabled by defining FX_REQUANT_OVF_CNT_EN.
module fx_requant_pipe #(
    parameter int IN_W       = 20,
    parameter int IN_FRAC    = 10,
    parameter int OUT_W      = 15,
    parameter int OUT_FRAC   = 7,
    parameter int ROUND_MODE = 1,
    parameter int SAT_MODE   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  i_data,
    input  logic             i_valid,
    output logic             i_ready,
    output logic [OUT_W-1:0] o_data,
    output logic             o_valid,
    input  logic             o_ready,
`ifdef FX_REQUANT_OVF_CNT_EN
    input  logic             i_cnt_clr,
    output logic [15:0]      o_ovf_cnt,
`endif
    output logic             o_ovf
);
    localparam int D   = IN_FRAC - OUT_FRAC;
    localparam int Q_W = IN_W - D + 1;
    localparam logic [IN_W:0]    HALF    = (IN_W+1)'(2**D / 2);
    localparam logic [IN_W:0]    HALF_M1 = HALF - (IN_W+1)'(1);
    localparam logic [OUT_W-1:0] MAX_V   = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_V   = {1'b1, {(OUT_W-1){1'b0}}};

    logic             s1_valid;
    logic [Q_W-1:0]   s1_q;
    logic             s1_free;
    logic             s2_free;
    logic [IN_W:0]    x_ext;
    logic [IN_W:0]    sum;
    logic [Q_W-1:0]   q;
    logic [OUT_W-1:0] res;
    logic             ovf;

    assign s2_free = ~o_valid | o_ready;
    assign s1_free = ~s1_valid | s2_free;
    assign i_ready = s1_free;

    // One extra bit of headroom keeps the rounding carry of the most positive input.
    assign x_ext = {i_data[IN_W-1], i_data};

    if (D == 0 || ROUND_MODE == 0) begin : g_floor
        assign sum = x_ext;
    end else if (ROUND_MODE == 1) begin : g_half_up
        assign sum = x_ext + HALF;
    end else begin : g_half_even
        assign sum = x_ext + HALF_M1 + {{IN_W{1'b0}}, i_data[D]};
    end

    assign q = Q_W'(sum >> D);

    if (Q_W > OUT_W) begin : g_range
        logic [Q_W-OUT_W:0] top;
        assign top = s1_q[Q_W-1:OUT_W-1];
        assign ovf = ~(&top | ~|top);
        if (SAT_MODE == 1) begin : g_sat
            assign res = ovf ? (s1_q[Q_W-1] ? MIN_V : MAX_V) : s1_q[OUT_W-1:0];
        end else begin : g_wrap
            assign res = s1_q[OUT_W-1:0];
        end
    end else begin : g_widen
        assign res = OUT_W'($signed(s1_q));
        assign ovf = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_ovf    <= 1'b0;
        end else begin
            if (s1_free) begin
                s1_valid <= i_valid;
                if (i_valid) s1_q <= q;
            end
            if (s2_free) begin
                o_valid <= s1_valid;
                if (s1_valid) begin
                    o_data <= res;
                    o_ovf  <= ovf;
                end
            end
        end
    end

`ifdef FX_REQUANT_OVF_CNT_EN
    // Clear has priority over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n || i_cnt_clr) begin
            o_ovf_cnt <= '0;
        end else if (o_valid && o_ready && o_ovf && (o_ovf_cnt != 16'hFFFF)) begin
            o_ovf_cnt <= o_ovf_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fx_requant_pipe.sv
// tb/tb_fx_requant_pipe.sv - randomized and directed bench for fx_requant_pipe across rounding/overflow modes.
module tb_fx_requant_pipe;
    localparam int RM [4] = '{1, 0, 2, 0};
    localparam int SM [4] = '{1, 1, 1, 0};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [19:0] i_data;
    logic [14:0] o_data  [4];
    logic        o_valid [4];
    logic        o_ovf   [4];
    logic        i_ready [4];
`ifdef FX_REQUANT_OVF_CNT_EN
    logic        i_cnt_clr;
    logic [15:0] o_ovf_cnt [4];
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          stall_end;
    logic [19:0] exp_q   [$];
    int          log_cyc [$];
    logic [14:0] log_dat [$];
    logic [19:0] mon_d;
    logic [15:0] mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        fx_requant_pipe #(.ROUND_MODE(RM[g]), .SAT_MODE(SM[g])) dut (
            .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready[g]),
            .o_data(o_data[g]), .o_valid(o_valid[g]), .o_ready(o_ready),
`ifdef FX_REQUANT_OVF_CNT_EN
            .i_cnt_clr(i_cnt_clr), .o_ovf_cnt(o_ovf_cnt[g]),
`endif
            .o_ovf(o_ovf[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: value/8 rounded per mode, then range-checked into 15-bit two's complement.
    function automatic logic [15:0] model(input logic [19:0] d, input int k);
        longint x, r, fl, q;
        x  = longint'($signed(d));
        r  = x % 8;
        if (r < 0) r += 8;
        fl = (x - r) / 8;
        case (RM[k])
            1:       q = (r >= 4) ? fl + 1 : fl;
            2:       q = (r > 4) ? fl + 1 : (r < 4) ? fl : ((fl % 2 != 0) ? fl + 1 : fl);
            default: q = fl;
        endcase
        if (q > 16383 || q < -16384) begin
            if (SM[k] == 1) return {1'b1, (q > 0) ? 15'h3FFF : 15'h4000};
            return {1'b1, q[14:0]};
        end
        return {1'b0, q[14:0]};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (o_valid[0] && o_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    mon_d = exp_q.pop_front();
                    for (int k = 0; k < 4; k++) begin
                        mon_e = model(mon_d, k);
                        check($sformatf("sb_data_i%0d_x%05h", k, mon_d), 32'(o_data[k]), 32'(mon_e[14:0]));
                        check($sformatf("sb_ovf_i%0d_x%05h", k, mon_d), 32'(o_ovf[k]), 32'(mon_e[15]));
                    end
                end
                log_cyc.push_back(cyc);
                log_dat.push_back(o_data[0]);
            end
            if (i_valid && i_ready[0]) exp_q.push_back(i_data);
        end
    end

    task automatic send(input logic [19:0] x);
        logic acc;
        i_data  = x;
        i_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            acc = i_ready[0];
            @(posedge clk);
            #1;
            if (acc) return;
        end
        check("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic directed(input logic [19:0] x, input logic [3:0][14:0] ed, input logic [3:0] eo);
        o_ready = 1'b1;
        check("dir_ready", 32'(i_ready[0]), 32'd1);
        send(x);
        i_valid = 1'b0;
        check("dir_lat1_valid", 32'(o_valid[0]), 32'd0);
        @(posedge clk);
        #1;
        check("dir_lat2_valid", 32'(o_valid[0]), 32'd1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("dir_data_i%0d_x%05h", k, x), 32'(o_data[k]), 32'(ed[3-k]));
            check($sformatf("dir_ovf_i%0d_x%05h", k, x), 32'(o_ovf[k]), 32'(eo[3-k]));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; o_ready = 1'b1; i_data = '0;
`ifdef FX_REQUANT_OVF_CNT_EN
        i_cnt_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_o_valid", 32'(o_valid[0]), 32'd0);
        check("rst_o_data", 32'(o_data[0]), 32'd0);
        check("rst_o_ovf", 32'(o_ovf[0]), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_i_ready", 32'(i_ready[0]), 32'd1);

        // Instance order: {half-up sat, floor sat, even sat, floor wrap}
        directed(20'h00014, {15'h0003, 15'h0002, 15'h0002, 15'h0002}, 4'b0000);
        directed(20'hFFFEC, {15'h7FFE, 15'h7FFD, 15'h7FFE, 15'h7FFD}, 4'b0000);
        directed(20'h7FFFF, {15'h3FFF, 15'h3FFF, 15'h3FFF, 15'h7FFF}, 4'b1111);
        directed(20'h80000, {15'h4000, 15'h4000, 15'h4000, 15'h0000}, 4'b1111);
        directed(20'h1FFFC, {15'h3FFF, 15'h3FFF, 15'h3FFF, 15'h3FFF}, 4'b1010);

        log_cyc.delete();
        log_dat.delete();
        fork
            begin
                for (int k = 1; k <= 8; k++) send(20'(k * 8));
                i_valid = 1'b0;
            end
            begin
                o_ready = 1'b1;
                repeat (2) @(posedge clk);
                #1 o_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                check("bp_i_ready_full", 32'(i_ready[0]), 32'd0);
                @(posedge clk);
                #1 o_ready = 1'b1;
                stall_end = cyc;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        check("bp_count", 32'(log_dat.size()), 32'd8);
        for (int k = 0; k < log_dat.size(); k++) begin
            check($sformatf("bp_order_%0d", k), 32'(log_dat[k]), 32'(k + 1));
            if (k > 0 && log_cyc[k-1] >= stall_end)
                check($sformatf("bp_gap_%0d", k), 32'(log_cyc[k] - log_cyc[k-1]), 32'd1);
        end

        o_ready = 1'b0;
        i_data  = 20'h00100;
        i_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        i_valid = 1'b0;
        rst_n   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mid_rst_o_valid", 32'(o_valid[0]), 32'd0);
        check("mid_rst_o_data", 32'(o_data[0]), 32'd0);
        check("mid_rst_i_ready", 32'(i_ready[0]), 32'd1);
        log_dat.delete();
        o_ready = 1'b1;
        send(20'h00028);
        i_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst_count", 32'(log_dat.size()), 32'd1);
        if (log_dat.size() > 0) check("mid_rst_first", 32'(log_dat[0]), 32'd5);

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 3))
                0:       i_data = 20'($urandom);
                1:       i_data = 20'($urandom_range(0, 63)) - 20'd32;
                2:       i_data = 20'h1FFF0 + 20'($urandom_range(0, 31));
                default: i_data = 20'hDFFF0 + 20'($urandom_range(0, 31));
            endcase
            i_valid = ($urandom_range(0, 3) != 0);
            o_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rand_drain_empty", 32'(exp_q.size()), 32'd0);

`ifdef FX_REQUANT_OVF_CNT_EN
        i_cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        i_cnt_clr = 1'b0;
        check("cnt_cleared", 32'(o_ovf_cnt[0]), 32'd0);
        for (int k = 0; k < 3; k++) send(20'h7FFFF);
        i_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("cnt_three", 32'(o_ovf_cnt[0]), 32'd3);
        send(20'h7FFFF);
        i_valid = 1'b0;
        @(posedge clk);
        #1;
        check("cnt_4th_valid", 32'(o_valid[0]), 32'd1);
        i_cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        i_cnt_clr = 1'b0;
        check("cnt_clear_wins", 32'(o_ovf_cnt[0]), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
